hilo_md_ctrl: RTL and testbench

- Sequencer for the HI/LO special-register write path.
- Accepts multiply, divide and move-to-HI/LO operations from decode.
- Starts the shared fixed-latency multiplier or the iterative divider (start/done handshake) and stalls the pipeline while they run.
- Drives the HI and LO write enables and 2-bit source selects when a result is ready.

---
 rtl/hilo_md_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hilo_md_ctrl.sv
// rtl/hilo_md_ctrl.sv - HI/LO write-path sequencer for multiply, divide and MTHI/MTLO
module hilo_md_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_MAX = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic       divisor_zero,
  output logic       op_ready,
  output logic       stall,
  output logic       mul_start,
  output logic       mul_signed,
  output logic       div_start,
  output logic       div_signed,
  input  logic       div_done,
  output logic       hi_wena,
  output logic [1:0] hi_select,
  output logic       lo_wena,
  output logic [1:0] lo_select,
  output logic       div_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    WRITE    = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] SEL_DIVU = 2'b00;
  localparam logic [1:0] SEL_MULU = 2'b10;
  localparam logic [1:0] SEL_RS   = 2'b11;

  // Multiply counts down from MUL_LAT-1; divide counts up to DIV_MAX-1.
  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT_LAST = 8'(DIV_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       op_ready_d, stall_d, mul_start_d, mul_signed_d;
  logic       div_start_d, div_signed_d, hi_wena_d, lo_wena_d, div_err_d;
  logic [1:0] hi_select_d, lo_select_d;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    hi_wena_d    = 1'b0;
    lo_wena_d    = 1'b0;
    div_err_d    = 1'b0;
    mul_signed_d = mul_signed;
    div_signed_d = div_signed;
    hi_select_d  = hi_select;
    lo_select_d  = lo_select;

    case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          case (op_code)
            OP_MULTU, OP_MULT: begin
              state_d      = MUL_WAIT;
              mul_start_d  = 1'b1;
              mul_signed_d = (op_code == OP_MULT);
              cnt_d        = MUL_CNT_INIT;
            end
            OP_DIVU, OP_DIV: begin
              if (divisor_zero) begin
                // Divide by zero never reaches the divider.
                div_err_d = 1'b1;
              end else begin
                state_d      = DIV_WAIT;
                div_start_d  = 1'b1;
                div_signed_d = (op_code == OP_DIV);
                cnt_d        = 8'd0;
              end
            end
            OP_MTHI: begin
              state_d     = WRITE;
              hi_wena_d   = 1'b1;
              hi_select_d = SEL_RS;
            end
            OP_MTLO: begin
              state_d     = WRITE;
              lo_wena_d   = 1'b1;
              lo_select_d = SEL_RS;
            end
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d     = WRITE;
          hi_wena_d   = 1'b1;
          lo_wena_d   = 1'b1;
          hi_select_d = SEL_MULU;
          lo_select_d = SEL_MULU;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DIV_WAIT: begin
        // A done on the last counted cycle still wins over the timeout.
        if (div_done) begin
          state_d     = WRITE;
          hi_wena_d   = 1'b1;
          lo_wena_d   = 1'b1;
          hi_select_d = {1'b0, div_signed};
          lo_select_d = {1'b0, div_signed};
        end else if (cnt_q == DIV_CNT_LAST) begin
          state_d   = IDLE;
          div_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    op_ready_d = (state_d == IDLE);
    stall_d    = ~op_ready_d;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      op_ready   <= 1'b1;
      stall      <= 1'b0;
      mul_start  <= 1'b0;
      mul_signed <= 1'b0;
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      hi_wena    <= 1'b0;
      hi_select  <= SEL_DIVU;
      lo_wena    <= 1'b0;
      lo_select  <= SEL_DIVU;
      div_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_ready   <= op_ready_d;
      stall      <= stall_d;
      mul_start  <= mul_start_d;
      mul_signed <= mul_signed_d;
      div_start  <= div_start_d;
      div_signed <= div_signed_d;
      hi_wena    <= hi_wena_d;
      hi_select  <= hi_select_d;
      lo_wena    <= lo_wena_d;
      lo_select  <= lo_select_d;
      div_err    <= div_err_d;
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// tb/tb_hilo_md_ctrl.sv - randomized self-checking bench for hilo_md_ctrl
module tb_hilo_md_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_MAX = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op_code;
  logic       divisor_zero;
  logic       div_done;
  logic       op_ready, stall, mul_start, mul_signed, div_start, div_signed;
  logic       hi_wena, lo_wena, div_err;
  logic [1:0] hi_select, lo_select;

  int checks   = 0;
  int failures = 0;

  // Architectural view: last signedness sent to each unit, last written selects.
  logic       m_mul_signed, m_div_signed;
  logic [1:0] m_hi_sel, m_lo_sel;

  logic [12:0] obs;
  assign obs = {op_ready, stall, mul_start, mul_signed, div_start, div_signed,
                hi_wena, hi_select, lo_wena, lo_select, div_err};

  hilo_md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_MAX(DIV_MAX)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .divisor_zero(divisor_zero), .op_ready(op_ready), .stall(stall),
    .mul_start(mul_start), .mul_signed(mul_signed), .div_start(div_start),
    .div_signed(div_signed), .div_done(div_done), .hi_wena(hi_wena),
    .hi_select(hi_select), .lo_wena(lo_wena), .lo_select(lo_select),
    .div_err(div_err)
  );

  always #5 clk = ~clk;

  // Compare one observed vector against its expectation.
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got rdy,stl,ms,msg,ds,dsg,hw,hs,lw,ls,err=%b expected %b", tag, got, exp);
    end
  endtask

  // Issue one op in the current (idle) cycle and check every cycle until idle again.
  // d: divide latency as counted cycles before done (>= DIV_MAX means never).
  // rst_req: cycle offset at which rst is driven (0 = none).
  task automatic run_op(input logic [2:0] code, input logic dz, input int d, input int rst_req);
    logic        is_mul, is_div, is_mt, tmo, rdy, hw, lw, err, in_wait;
    int          wk, e, ra;
    logic [12:0] exp;
    is_mul = (code == 3'd1) || (code == 3'd2);
    is_div = (code == 3'd3) || (code == 3'd4);
    is_mt  = (code == 3'd5) || (code == 3'd6);
    tmo    = is_div && !dz && (d >= DIV_MAX);
    wk     = -1;
    if (is_mul) begin wk = 1 + MUL_LAT; e = 2 + MUL_LAT; end
    else if (is_div && dz) e = 1;
    else if (tmo) e = 1 + DIV_MAX;
    else if (is_div) begin wk = 2 + d; e = 3 + d; end
    else if (is_mt) begin wk = 1; e = 2; end
    else e = 1;
    ra = 0;
    if (rst_req > 0 && rst_req < e) begin ra = rst_req; e = ra + 1; end

    op_valid     = 1'b1;
    op_code      = code;
    divisor_zero = dz;
    div_done     = 1'($urandom_range(0, 1));

    for (int k = 1; k <= e; k++) begin
      @(negedge clk);
      if (ra > 0 && k == ra + 1) begin
        m_mul_signed = 1'b0;
        m_div_signed = 1'b0;
        m_hi_sel     = 2'b00;
        m_lo_sel     = 2'b00;
        exp          = {1'b1, 12'b0};
      end else begin
        if (k == 1 && is_mul) m_mul_signed = (code == 3'd2);
        if (k == 1 && is_div && !dz) m_div_signed = (code == 3'd4);
        hw = (k == wk) && (is_mul || is_div || code == 3'd5);
        lw = (k == wk) && (is_mul || is_div || code == 3'd6);
        if (k == wk) begin
          if (is_mul) begin m_hi_sel = 2'b10; m_lo_sel = 2'b10; end
          else if (is_div) begin
            m_hi_sel = (code == 3'd4) ? 2'b01 : 2'b00;
            m_lo_sel = m_hi_sel;
          end
          else if (code == 3'd5) m_hi_sel = 2'b11;
          else m_lo_sel = 2'b11;
        end
        rdy = (k == e);
        err = is_div && ((dz && k == 1) || (tmo && k == 1 + DIV_MAX));
        exp = {rdy, !rdy, is_mul && k == 1, m_mul_signed, is_div && !dz && k == 1,
               m_div_signed, hw, m_hi_sel, lw, m_lo_sel, err};
      end
      check($sformatf("op%0d dz%0d d%0d rst%0d k%0d", code, dz, d, ra, k), obs, exp);

      rst = (ra > 0 && k == ra);
      if (k < e) begin
        op_valid     = 1'($urandom_range(0, 1));
        op_code      = 3'($urandom_range(0, 7));
        divisor_zero = 1'($urandom_range(0, 1));
      end else begin
        op_valid = 1'b0;
      end
      in_wait = is_div && !dz && (tmo ? (k <= DIV_MAX) : (k <= 1 + d));
      if (in_wait) div_done = !tmo && (k == 1 + d);
      else div_done = 1'($urandom_range(0, 1));
    end
    rst = 1'b0;
  endtask

  initial begin
    int d, ra;
    logic [2:0] c;
    rst          = 1'b1;
    op_valid     = 1'b0;
    op_code      = 3'd0;
    divisor_zero = 1'b0;
    div_done     = 1'b0;
    m_mul_signed = 1'b0;
    m_div_signed = 1'b0;
    m_hi_sel     = 2'b00;
    m_lo_sel     = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", obs, {1'b1, 12'b0});
    rst = 1'b0;

    run_op(3'd1, 1'b0, 0, 0);            // MULTU
    run_op(3'd4, 1'b0, 5, 0);            // DIV, done 5 cycles after div_start
    run_op(3'd3, 1'b1, 0, 0);            // DIVU by zero
    run_op(3'd3, 1'b0, DIV_MAX, 0);      // DIVU timeout
    run_op(3'd4, 1'b0, DIV_MAX - 1, 0);  // DIV done on the last counted cycle
    run_op(3'd5, 1'b0, 0, 0);            // MTHI
    run_op(3'd6, 1'b0, 0, 0);            // MTLO back-to-back
    run_op(3'd2, 1'b0, 0, 2);            // MULT aborted by reset
    run_op(3'd0, 1'b0, 0, 0);            // no-op codes
    run_op(3'd7, 1'b0, 0, 0);
    run_op(3'd4, 1'b0, 0, 0);            // DIV done immediately

    for (int i = 0; i < 80; i++) begin
      c  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8))
                                       : int'($urandom_range(0, DIV_MAX + 3));
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_op(c, 1'($urandom_range(0, 3) == 0), d, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
